// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, NOP encoding
// and the fetch FSM state type.
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  // addi x0, x0, 0 -- what decode sees when no instruction has been fetched.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // IDLE : no memory request outstanding
  // WAIT : request outstanding, its data will be delivered to decode
  // DRAIN: request outstanding, its data will be thrown away (flushed)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction for decode.
// Flush wins over load; an accepted instruction empties the register unless
// a new one is loaded in the same cycle.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [ILEN-1:0] load_instr,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr
);

  // Register update: reset to NOP, then flush > load > drain-on-accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory request at a time at the
// current PC, delivers the returned word to decode through the IF/ID
// register, and tells the PC register when to advance. A redirect (flush)
// never retracts an outstanding request; the late response is drained.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_next_seq,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr
);

  fetch_state_t    state;
  logic [XLEN-1:0] req_pc;
  logic            can_issue;
  logic            issue;
  logic            ack_taken;
  logic            deliver;

  // A new request may start only when the output slot is free (or being
  // emptied this cycle) and no redirect is in progress.
  assign can_issue = !id_valid || id_ready;
  assign issue     = (state == ST_IDLE) && can_issue && !flush;

  // Once outstanding, the request stays up until acknowledged; reset
  // silences everything because the memory is reset alongside us.
  assign imem_req  = !reset && (issue || (state != ST_IDLE));
  assign imem_addr = (state == ST_IDLE) ? pc_in : req_pc;

  // An ack only counts against a live request; drained or flushed
  // responses never reach decode.
  assign ack_taken = imem_req && imem_ack;
  assign deliver   = ack_taken && !flush && (state != ST_DRAIN);

  // The PC advances once per delivered instruction, or loads the redirect
  // target whenever flush is high.
  assign pc_write    = !reset && (flush || deliver);
  assign pc_next_seq = pc_in + XLEN'(4);

  // Request-tracking FSM; req_pc freezes the address of the issued request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      req_pc <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            req_pc <= pc_in;
            if (!imem_ack) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            state <= ST_IDLE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .ILEN      (ILEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (deliver),
    .load_pc    (imem_addr),
    .load_instr (imem_rdata),
    .ready      (id_ready),
    .valid      (id_valid),
    .pc         (id_pc),
    .instr      (id_instr)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The bench owns the PC register
// and the instruction memory, and keeps a transaction-level model: one
// optional outstanding request (address + discard flag) and one output slot.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        pc_write;
  logic [63:0] pc_next_seq;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  int checks = 0;
  int errors = 0;

  // model state
  logic [63:0] pc_reg = '0;
  logic        m_valid = 1'b0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_instr = 32'h0000_0013;
  logic        m_pend = 1'b0;
  logic [63:0] m_paddr = '0;
  logic        m_disc = 1'b0;

  // per-cycle expectations / stimulus
  logic        e_req, e_take, e_deliver, e_pcw;
  logic [63:0] e_addr;
  logic        cur_f, cur_rdy;
  logic [63:0] cur_tgt;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_write    (pc_write),
    .pc_next_seq (pc_next_seq),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[63:34], 2'b01} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called at posedge+1), then compare outputs.
  task automatic apply(input logic f, input logic rdy, input logic ak,
                       input logic use_mem, input logic [31:0] rd, input logic [63:0] tgt);
    cur_f   = f;
    cur_rdy = rdy;
    cur_tgt = tgt;
    flush    = f;
    id_ready = rdy;
    pc_in    = pc_reg;
    e_req  = m_pend || (!f && (!m_valid || rdy));
    e_addr = m_pend ? m_paddr : pc_reg;
    imem_ack   = ak;
    imem_rdata = use_mem ? mem_word(e_addr) : rd;
    e_take    = e_req && ak;
    e_deliver = e_take && !f && !m_disc;
    e_pcw     = f || e_deliver;
    #1;
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("pc_write", pc_write, e_pcw);
    chk("pc_next_seq", pc_next_seq, pc_reg + 64'd4);
    chk("id_valid", id_valid, m_valid);
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_instr", id_instr, m_instr);
    end
  endtask

  // Clock edge: advance the model with the same inputs, end at posedge+1.
  task automatic advance();
    @(posedge clk);
    if (e_pcw) pc_reg = cur_f ? cur_tgt : pc_reg + 64'd4;
    if (cur_f) m_valid = 1'b0;
    else if (e_deliver) begin
      m_valid = 1'b1;
      m_pc    = e_addr;
      m_instr = imem_rdata;
    end else if (m_valid && cur_rdy) m_valid = 1'b0;
    if (e_take) begin
      m_pend = 1'b0;
      m_disc = 1'b0;
    end else if (e_req) begin
      if (!m_pend) m_paddr = e_addr;
      m_pend = 1'b1;
      m_disc = m_disc | cur_f;
    end
    #1;
  endtask

  // Assert reset (called at posedge+1), check the forced values, release.
  task automatic do_reset(input logic [63:0] new_pc);
    reset = 1'b1;
    #1;
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, 64'h13);
    chk("rst_id_pc", id_pc, 64'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_instr = 32'h0000_0013;
    m_pc    = '0;
    m_pend  = 1'b0;
    m_disc  = 1'b0;
    pc_reg  = new_pc;
    reset   = 1'b0;
  endtask

  initial begin
    #2;
    do_reset(64'h0);

    // zero-wait fetch from 0
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0050_0093, 64'h0);
    chk("r040_pcw", pc_write, 1'b1);
    advance();
    chk("r040_valid", id_valid, 1'b1);
    chk("r040_pc", id_pc, 64'h0);
    chk("r040_instr", id_instr, 64'h0050_0093);

    // three wait states at 0x100
    pc_reg = 64'h100;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, (i == 3), 1'b0, 32'h00A0_0113, 64'h0);
      chk("r041_req", imem_req, 1'b1);
      chk("r041_addr", imem_addr, 64'h100);
      chk("r041_pcw", pc_write, (i == 3));
      advance();
    end
    chk("r041_valid", id_valid, 1'b1);
    chk("r041_pc", id_pc, 64'h100);
    chk("r041_instr", id_instr, 64'h00A0_0113);

    // decode stall; stray acks must be ignored
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 64'h0);
      chk("r042_req", imem_req, 1'b0);
      chk("r042_pcw", pc_write, 1'b0);
      chk("r042_pc", id_pc, 64'h100);
      chk("r042_instr", id_instr, 64'h00A0_0113);
      advance();
    end

    // flush while waiting: late data drained
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 64'h2000);
    chk("r043_flush_pcw", pc_write, 1'b1);
    chk("r043_flush_req", imem_req, 1'b1);
    advance();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("r043_drain_addr", imem_addr, 64'h104);
    chk("r043_drain_valid", id_valid, 1'b0);
    advance();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 64'h0);
    chk("r043_drain_pcw", pc_write, 1'b0);
    advance();
    chk("r043_after_valid", id_valid, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 64'h0);
    chk("r043_new_addr", imem_addr, 64'h2000);
    advance();
    chk("r043_new_pc", id_pc, 64'h2000);
    chk("r043_new_instr", id_instr, mem_word(64'h2000));

    // reset in the middle of a request
    apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0);
    chk("r044_wait_req", imem_req, 1'b1);
    advance();
    do_reset(64'h3000);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 64'h0);
    chk("r044_first_addr", imem_addr, 64'h3000);
    advance();

    // sequential PC wraps
    pc_reg = 64'hFFFF_FFFF_FFFF_FFFC;
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 64'h0);
    chk("wrap_next_seq", pc_next_seq, 64'h0);
    advance();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic        f, rdy, ak;
      logic [63:0] tgt;
      if ($urandom_range(0, 399) == 0) do_reset({$urandom(), $urandom()} & ~64'h3);
      f   = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ak  = ((c / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 9) < 6);
      tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4
                                        : ({$urandom(), $urandom()} & ~64'h3);
      apply(f, rdy, ak, 1'b1, 32'h0, tgt);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter XLEN, 64, PC and address width.
REQ-002 Parameter ILEN, 32, instruction width.
REQ-003 Parameter NOP_INSTR, 32'h00000013, instruction value held in id_instr at reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 pc_in  input  XLEN  current PC from the program counter register.
REQ-007 pc_write  output  1  PC load enable; high lets the PC register load its input on the next edge.
REQ-008 pc_next_seq  output  XLEN  pc_in + 4, for the upstream next-PC mux.
REQ-009 flush  input  1  redirect; upstream mux selects the branch target while flush is high.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  XLEN  request address.
REQ-012 imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle.
REQ-013 imem_rdata  input  ILEN  fetched instruction.
REQ-014 id_valid  output  1  id_pc and id_instr hold a valid instruction for decode.
REQ-015 id_ready  input  1  decode accepts on clk edge when id_valid && id_ready.
REQ-016 id_pc  output  XLEN  PC of the held instruction.
REQ-017 id_instr  output  ILEN  held instruction.

Function
REQ-018 FSM states: IDLE (no request outstanding), WAIT (request outstanding, result wanted), DRAIN (request outstanding, result to be discarded).
REQ-019 can_issue = !id_valid || id_ready; imem_req = (IDLE && can_issue && !flush) || WAIT || DRAIN.
REQ-020 imem_addr = pc_in in IDLE; otherwise req_pc, latched from pc_in on the issue cycle; imem_addr stays stable while imem_req is high.
REQ-021 imem_req, once high, stays high until imem_ack; the request is never retracted, including on flush.
REQ-022 imem_ack while imem_req is low is ignored.
REQ-023 IDLE: issue with ack in the same cycle loads the output register and the FSM stays in IDLE; issue without ack moves the FSM to WAIT.
REQ-024 WAIT: on ack, load the output register and go to IDLE; the output register is empty in WAIT by construction.
REQ-025 Output register load: id_valid<=1, id_pc<=request address, id_instr<=imem_rdata.
REQ-026 The output register clears (id_valid<=0) when id_valid && id_ready and no load occurs in the same cycle.
REQ-027 pc_write = flush || (ack accepted in IDLE or WAIT without flush); it is combinational, with a one-cycle pulse per accepted instruction.
REQ-028 Zero-wait memory with id_ready held high: one instruction per cycle; id_valid rises one cycle after issue.
REQ-029 flush has priority over all events: id_valid<=0 next edge; an ack in the flush cycle is discarded.
REQ-030 flush in WAIT without ack moves the FSM to DRAIN.
REQ-031 flush in IDLE stays in IDLE and issues nothing that cycle.
REQ-032 flush in DRAIN stays in DRAIN.
REQ-033 DRAIN: ack discards data and moves the FSM to IDLE; pc_write=0 unless flush is high.
REQ-034 pc_next_seq wraps modulo 2^XLEN (FFFF_FFFF_FFFF_FFFC+4 = 0).

Reset
REQ-035 Asserting reset, at any point including mid-request, forces state=IDLE, id_valid=0, id_pc=0, id_instr=NOP_INSTR, req_pc=0.
REQ-036 An outstanding request is abandoned on reset; the memory is reset concurrently.
REQ-037 pc_write=0 and imem_req=0 while reset is high.

Structure
REQ-038 Shared package fetch_pkg holds: FSM state enumeration, XLEN/ILEN defaults, NOP_INSTR constant.
REQ-039 Sub-module if_id_reg implements the output register: load, drain, flush, and reset-to-NOP behaviour.

Verification
REQ-040 Reset then release, pc_in=0x0, zero-wait ack, rdata=0x00500093, id_ready=1 -> cycle 1: id_valid=1, id_pc=0x0, id_instr=0x00500093, one pc_write pulse.
REQ-041 Ack delayed 3 cycles, pc_in=0x100 -> imem_req high and imem_addr=0x100 for 4 cycles, pc_write=0 until ack cycle, then id_pc=0x100.
REQ-042 id_valid=1, id_ready=0 for 5 cycles -> imem_req=0, pc_write=0, id_pc/id_instr unchanged throughout.
REQ-043 flush in WAIT, ack 2 cycles later with rdata=0xDEADBEEF -> FSM in DRAIN, id_valid stays 0, 0xDEADBEEF never appears, next request uses the new pc_in.
REQ-044 Reset asserted while in WAIT -> id_valid=0, id_instr=0x00000013 immediately; after release, first request address equals pc_in.
